// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes
// and the controller state encoding.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Works on magnitudes for WIDTH cycles, then applies sign correction in FIX.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  mdu_state_t           state;
  mdu_op_t              op_q;
  logic [WIDTH-1:0]     a_raw;
  logic [WIDTH-1:0]     b_abs;
  logic                 neg_res;
  logic                 neg_rem;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;

  logic                 in_signed;
  logic [WIDTH-1:0]     a_in_abs;
  logic [WIDTH-1:0]     b_in_abs;
  logic                 is_div;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  // Operand magnitudes at launch; unsigned ops pass the raw value through.
  always_comb begin
    in_signed = op[0];
    a_in_abs  = cneg(a, in_signed & a[WIDTH-1]);
    b_in_abs  = cneg(b, in_signed & b[WIDTH-1]);
  end

  // One iteration: acc low half holds the multiplier bits (multiply) or the
  // dividend bits being shifted out while quotient bits shift in (divide).
  always_comb begin
    is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_abs} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_abs};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!div_trial[WIDTH])
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_res ? (~acc + (2*WIDTH)'(1)) : acc;
    quot_fix = cneg(acc[WIDTH-1:0], neg_res);
    rem_fix  = cneg(acc[2*WIDTH-1:WIDTH], neg_rem);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_MULTU;
      a_raw    <= '0;
      b_abs    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      // MTHI/MTLO only land while no operation owns HI/LO.
      if (state == S_IDLE || state == S_DONE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= mdu_op_t'(op);
            a_raw    <= a;
            b_abs    <= b_in_abs;
            neg_res  <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= in_signed & a[WIDTH-1];
            acc      <= {{WIDTH{1'b0}}, a_in_abs};
            cnt      <= CNT_W'(WIDTH);
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            if (b_abs == '0) begin
              hi       <= a_raw;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter: a 32-bit and an 8-bit instance checked
// against hand-computed results, latencies and HI/LO write rules.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0;
  logic [1:0]  op32 = 2'b00;
  logic [31:0] a32 = '0, b32 = '0, wdata32 = '0;
  logic        hi_we32 = 1'b0, lo_we32 = 1'b0;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0, wdata8 = '0;
  logic        hi_we8 = 1'b0, lo_we8 = 1'b0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wdata32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  // Launch: start is high for one cycle (cycle 0); returns at the sample point of cycle 1.
  task automatic launch32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic launch8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Advance until done, bounded; reports the done cycle and whether busy tracked correctly.
  task automatic wait32(input int first, output int cyc, output bit busy_ok);
    cyc = first; busy_ok = 1'b1;
    while (done32 !== 1'b1 && cyc < 200) begin
      if (busy32 !== 1'b1) busy_ok = 1'b0;
      @(negedge clk); cyc++;
    end
    if (busy32 !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic wait8(output int cyc);
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 200) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (busy32 !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy32); else n_pass++;
    n_checks++; if (done32 !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done32); else n_pass++;
    n_checks++; if (dz32 !== 1'b0) $display("[TB] FAIL reset_div_zero: got %b expected 0", dz32); else n_pass++;
    n_checks++; if ({hi32, lo32} !== 64'h0) $display("[TB] FAIL reset_hilo: got %h_%h expected 0", hi32, lo32); else n_pass++;
    n_checks++; if ({busy8, hi8, lo8} !== 17'h0) $display("[TB] FAIL reset_w8: got busy=%b hi=%h lo=%h expected 0", busy8, hi8, lo8); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_mult_latency;
    int cyc; bit bok;
    launch32(OP_MULT, 32'hFFFFFFFD, 32'd7);
    wait32(1, cyc, bok);
    n_checks++; if (cyc !== 34) $display("[TB] FAIL mult_done_cycle: got %0d expected 34", cyc); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("[TB] FAIL mult_busy_window: got %b expected 1", bok); else n_pass++;
    n_checks++; if (hi32 !== 32'hFFFFFFFF) $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi32); else n_pass++;
    n_checks++; if (lo32 !== 32'hFFFFFFEB) $display("[TB] FAIL mult_lo: got %h expected ffffffeb", lo32); else n_pass++;
    @(negedge clk);
    n_checks++; if (done32 !== 1'b0) $display("[TB] FAIL done_one_pulse: got %b expected 0", done32); else n_pass++;
  endtask

  task automatic test_multu;
    int cyc; bit bok;
    launch32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait32(1, cyc, bok);
    n_checks++; if ({hi32, lo32} !== 64'hFFFFFFFE_00000001) $display("[TB] FAIL multu_max: got %h_%h expected fffffffe_00000001", hi32, lo32); else n_pass++;
    launch32(OP_MULTU, 32'h0, 32'h12345678);
    wait32(1, cyc, bok);
    n_checks++; if ({hi32, lo32} !== 64'h0) $display("[TB] FAIL multu_zero: got %h_%h expected 0", hi32, lo32); else n_pass++;
  endtask

  task automatic test_div;
    int cyc; bit bok;
    launch32(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait32(1, cyc, bok);
    n_checks++; if (lo32 !== 32'hFFFFFFFD) $display("[TB] FAIL div_quot: got %h expected fffffffd", lo32); else n_pass++;
    n_checks++; if (hi32 !== 32'hFFFFFFFF) $display("[TB] FAIL div_rem: got %h expected ffffffff", hi32); else n_pass++;
    launch32(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait32(1, cyc, bok);
    n_checks++; if ({hi32, lo32} !== 64'h00000000_80000000) $display("[TB] FAIL div_overflow: got %h_%h expected 00000000_80000000", hi32, lo32); else n_pass++;
    n_checks++; if (dz32 !== 1'b0) $display("[TB] FAIL div_overflow_flag: got %b expected 0", dz32); else n_pass++;
  endtask

  task automatic test_div_zero;
    int cyc; bit bok;
    launch32(OP_DIVU, 32'd100, 32'd0);
    wait32(1, cyc, bok);
    n_checks++; if (cyc !== 34) $display("[TB] FAIL divz_done_cycle: got %0d expected 34", cyc); else n_pass++;
    n_checks++; if ({hi32, lo32} !== 64'h00000064_FFFFFFFF) $display("[TB] FAIL divz_result: got %h_%h expected 00000064_ffffffff", hi32, lo32); else n_pass++;
    n_checks++; if (dz32 !== 1'b1) $display("[TB] FAIL divz_flag: got %b expected 1", dz32); else n_pass++;
    @(negedge clk);
    n_checks++; if (dz32 !== 1'b1) $display("[TB] FAIL divz_sticky: got %b expected 1", dz32); else n_pass++;
    launch32(OP_MULTU, 32'd2, 32'd2);
    n_checks++; if (dz32 !== 1'b0) $display("[TB] FAIL divz_clear: got %b expected 0", dz32); else n_pass++;
    wait32(1, cyc, bok);
    n_checks++; if (lo32 !== 32'd4) $display("[TB] FAIL multu_small: got %h expected 4", lo32); else n_pass++;
  endtask

  task automatic test_start_ignored;
    int cyc; bit bok;
    launch32(OP_MULTU, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    op32 = OP_MULT; a32 = 32'd7; b32 = 32'd9; start32 = 1'b1;
    hi_we32 = 1'b1; wdata32 = 32'hAAAA;
    @(negedge clk);
    start32 = 1'b0; hi_we32 = 1'b0;
    n_checks++; if (hi32 !== 32'h0) $display("[TB] FAIL busy_mthi_ignored: got %h expected 0", hi32); else n_pass++;
    wait32(11, cyc, bok);
    n_checks++; if (cyc !== 34) $display("[TB] FAIL busy_start_cycle: got %0d expected 34", cyc); else n_pass++;
    n_checks++; if ({hi32, lo32} !== 64'h00000000_0000000F) $display("[TB] FAIL busy_start_ignored: got %h_%h expected 00000000_0000000f", hi32, lo32); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    int dones;
    launch32(OP_MULTU, 32'd3, 32'd5);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy32 !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy32); else n_pass++;
    n_checks++; if ({hi32, lo32} !== 64'h0) $display("[TB] FAIL abort_hilo: got %h_%h expected 0", hi32, lo32); else n_pass++;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32 === 1'b1) dones++;
      @(negedge clk);
    end
    n_checks++; if (dones !== 0) $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", dones); else n_pass++;
  endtask

  task automatic test_mtlo;
    lo_we32 = 1'b1; wdata32 = 32'h1234;
    @(negedge clk);
    lo_we32 = 1'b0;
    n_checks++; if ({hi32, lo32} !== 64'h00000000_00001234) $display("[TB] FAIL mtlo: got %h_%h expected 00000000_00001234", hi32, lo32); else n_pass++;
    hi_we32 = 1'b1; lo_we32 = 1'b1; wdata32 = 32'h5555;
    @(negedge clk);
    hi_we32 = 1'b0; lo_we32 = 1'b0;
    n_checks++; if ({hi32, lo32} !== 64'h00005555_00005555) $display("[TB] FAIL mthi_mtlo: got %h_%h expected 00005555_00005555", hi32, lo32); else n_pass++;
  endtask

  task automatic test_width8;
    int cyc;
    launch8(OP_MULT, 8'hFD, 8'd7);
    wait8(cyc);
    n_checks++; if (cyc !== 10) $display("[TB] FAIL w8_done_cycle: got %0d expected 10", cyc); else n_pass++;
    n_checks++; if ({hi8, lo8} !== 16'hFFEB) $display("[TB] FAIL w8_mult: got %h_%h expected ff_eb", hi8, lo8); else n_pass++;
    launch8(OP_MULTU, 8'hFF, 8'hFF);
    wait8(cyc);
    n_checks++; if ({hi8, lo8} !== 16'hFE01) $display("[TB] FAIL w8_multu: got %h_%h expected fe_01", hi8, lo8); else n_pass++;
    launch8(OP_DIV, 8'hF9, 8'd2);
    wait8(cyc);
    n_checks++; if ({hi8, lo8} !== 16'hFFFD) $display("[TB] FAIL w8_div: got %h_%h expected ff_fd", hi8, lo8); else n_pass++;
    launch8(OP_DIV, 8'h80, 8'hFF);
    wait8(cyc);
    n_checks++; if ({hi8, lo8} !== 16'h0080) $display("[TB] FAIL w8_div_overflow: got %h_%h expected 00_80", hi8, lo8); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_mult_latency;
    test_multu;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_reset_mid_op;
    test_mtlo;
    test_width8;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parameterised iterative multiply/divide unit with architectural HI/LO registers. Serves MULT, MULTU, DIV, DIVU, MFHI/MFLO, MTHI/MTLO for the multi-cycle CPU.
- Sits beside the ALU in the multi-cycle datapath. The controller holds the FSM in an execute-wait state while busy is high.
- Adds width generality, signed and unsigned modes, and a start/busy/done handshake that the single-cycle ALU does not have.

Parameters:
WIDTH, 32, operand, HI and LO width (any value ≥ 4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  launch an operation; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  in  WIDTH  multiplicand / dividend (rs)
b  in  WIDTH  multiplier / divisor (rt)
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse; HI/LO hold the new result
div_zero  out  1  sticky until the next accepted start; last divide had b==0
hi  out  WIDTH  HI register (MFHI source)
lo  out  WIDTH  LO register (MFLO source)

Behaviour:
- Reset values:
  - State goes to IDLE.
  - busy=0, done=0, div_zero=0, hi=0, lo=0.
  - Reset mid-operation aborts the operation; HI/LO are not updated with partial results.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 latches op, |a|, |b| and the sign flags, sets the counter to WIDTH, and moves to CALC. |x| applies for signed ops only; unsigned ops latch the raw value.
- CALC: one iteration per cycle. Decrement the counter; at 1, move to FIX. This gives exactly WIDTH cycles.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient bit is 1 when the trial subtraction is non-negative.
- FIX: sign correction, then HI/LO are written at the end of the cycle.
  - MULT: negate the 2*WIDTH product when sign(a)≠sign(b).
  - DIV: negate the quotient when sign(a)≠sign(b); the remainder takes the sign of a.
  - Result placement: HI = product[2W-1:W], LO = product[W-1:0]; for divides, HI = remainder, LO = quotient.
- DONE: done=1 for one cycle, busy=0, then return to IDLE. A start in DONE is ignored; the controller starts again from IDLE.
- Latency: start in cycle 0 → busy=1 in cycles 1..WIDTH+1 → done=1 and new hi/lo visible in cycle WIDTH+2. Latency is fixed and independent of operand values.
- Divide by zero (b==0, DIVU or DIV):
  - Same latency as a normal divide.
  - Result: LO = all ones, HI = a (raw, unsigned).
  - div_zero is set in FIX.
- Signed overflow (DIV with a = most-negative value, b = −1): LO = most-negative value, HI = 0. No flag is raised.
- start while busy (CALC or FIX): ignored; latched operands are unchanged.
- hi_we/lo_we:
  - Honoured only in IDLE and DONE; ignored in CALC and FIX.
  - In the cycle start is accepted, the write takes effect, but FIX later overwrites it.
  - hi_we and lo_we together write wdata to both registers.
- hi and lo are direct register outputs with no combinational path from the inputs.
- All arithmetic is WIDTH-bit two's complement. Negation is ~x+1 and wraps.

Decomposition:
- Package mdu_pkg holds:
  - the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state encoding (S_IDLE, S_CALC, S_FIX, S_DONE), 2 bits.
- Single module. No sub-module is needed; the shared conditional-negate logic is a local function.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD, b=7, start at cycle 0 → busy cycles 1..33; done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; MULTU 0×anything → hi=lo=0.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- DIVU a=100, b=0 → done in cycle 34, lo=0xFFFFFFFF, hi=0x00000064, div_zero=1. The next accepted start clears div_zero.
- Launch MULTU 3×5, then in cycle 10:
  - start with other operands, plus hi_we with wdata=0xAAAA → both ignored; result hi=0, lo=15.
  - Repeat the operation, assert reset in cycle 20 → next cycle busy=0, hi=lo=0, no done pulse.
  - MTLO in IDLE with wdata=0x1234 → lo=0x1234 the next cycle.
- Rerun the MULT, MULTU and DIV cases with WIDTH=8 → done in cycle 10, results truncated to 8-bit semantics.
